// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_FILTER_LEN   = 8;
  localparam int DEFAULT_TIMEOUT_CLKS = 2000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 line inputs plus received-byte / status outputs of the frame receiver.
// Outputs are level/pulse registers with no backpressure: byte_valid, parity_err
// and frame_err are single-cycle strobes the consumer must take when high.
interface ps2_frame_receiver_if;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       enable_rcv;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output ps2clk_in, ps2data_in, enable_rcv,
    input  byte_out, byte_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  ps2clk_in, ps2data_in, enable_rcv,
    output byte_out, byte_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce that only flips the output
// after FILTER_LEN consecutive synchronized samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta_q, sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synchronized sample matches the output,
  // so only an unbroken run of the opposite level can flip it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q;
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: filters both lines, decodes
// start/8 data/odd parity/stop on falling clock edges, with timeout abort.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN   = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_frame_receiver_if.slave  bus,
  output ps2_state_e           dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic clk_f, data_f, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .rst      (rst),
    .line_in  (bus.ps2clk_in),
    .line_out (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .rst      (rst),
    .line_in  (bus.ps2data_in),
    .line_out (data_f)
  );

  ps2_state_e     state_q, state_d;
  logic           clk_prev_q;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     byte_q, byte_d;
  logic           bv_q, bv_d;
  logic           pe_q, pe_d;
  logic           fe_q, fe_d;
  logic           busy_q, busy_d;

  assign fall = clk_prev_q & ~clk_f;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    byte_d    = byte_q;
    bv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;

    if (state_q == IDLE) begin
      tmo_d = '0;
      if (fall && bus.enable_rcv && !data_f) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
    end else if (!bus.enable_rcv) begin
      // Host has taken the bus to transmit: drop the frame without reporting.
      state_d = IDLE;
      tmo_d   = '0;
    end else if (fall) begin
      // An edge beats a coincident timeout.
      tmo_d = '0;
      case (state_q)
        DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_f;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_f) begin
            fe_d = 1'b1;
          end else if (^{shift_q, par_q}) begin
            byte_d = shift_q;
            bv_d   = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
      fe_d    = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= 8'h00;
      bv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_prev_q <= clk_f;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      bv_q       <= bv_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = bv_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state_q;

endmodule
